topo2a_mul_arbiter: RTL and testbench
=====================================

// Module: topo2a_mul_arbiter
// PURPOSE
//  Round-robin arbiter that time-shares one 16s x 10u multiplier among NREQ requesters.
//  Requesters are the projection/dense-layer lanes of the Topo2A AD path.
//  Each requester offers operand pairs (valid/ready). The block registers the winner's
//  operands, drives the external multiplier and pipelines the product.
//  It returns the product with a one-hot tag. A flush FSM drains the pipeline on request.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  A_W      16  signed operand width (din0)
//  B_W      10  unsigned operand width (din1)
//  P_W      25  product width returned (LSBs of the full A_W+B_W product)
//  MUL_LAT  1   product pipeline stages after the multiplier (>=1)
// PORTS
//  ap_clk     in   1         clock, all logic rising-edge
//  ap_rst     in   1         synchronous reset, active-high
//  req_valid  in   NREQ      per-requester operand valid
//  req_ready  out  NREQ      one-hot grant; transfer when valid&ready
//  req_a      in   NREQ*A_W  signed operands, requester i at [i*A_W +: A_W]
//  req_b      in   NREQ*B_W  unsigned operands, requester i at [i*B_W +: B_W]
//  mul_din0   out  A_W       registered operand A to the shared multiplier
//  mul_din1   out  B_W       registered operand B to the shared multiplier
//  mul_dout   in   P_W       combinational product from the multiplier
//  res_valid  out  NREQ      one-hot, 1-cycle pulse: result for requester i
//  res_data   out  P_W       product, valid when |res_valid
//  flush      in   1         request drain: stop granting, empty the pipeline
//  idle       out  1         1 when in HALT, or in RUN with an empty pipeline and no grant
//  inflight   out  clog2(MUL_LAT+2)  number of accepted-but-unreturned ops
// BEHAVIOUR
//  Reset (ap_rst=1 at an edge)
//   - req_ready, res_valid, mul_din0/1, res_data and inflight are 0; idle is 1.
//   - RR pointer is 0; FSM is RUN; all stage valids clear.
//   - In-flight ops are discarded; no res_valid appears for them after reset.
//  Arbitration (RUN only)
//   - req_ready is combinational from req_valid and the pointer.
//   - It grants the first valid requester at or after the pointer, at most one per cycle.
//   - Requesters must not make req_valid depend on req_ready.
//   - After a grant to i, pointer <= (i+1) mod NREQ. With no grant, the pointer holds.
//   - Throughput is 1 op per cycle. There is no result backpressure; requesters always accept.
//  Pipeline and latency
//   - Accept at edge t: operands and one-hot tag are registered onto mul_din0/1 for cycle t+1.
//   - mul_dout is captured into stage 1, then shifted through MUL_LAT stages.
//   - res_valid/res_data assert in cycle t+1+MUL_LAT (MUL_LAT=1: 2 cycles after acceptance).
//   - Idle stages hold mul_din0/1 at the last value; res_data is 0 when no res_valid.
//  Arithmetic
//   - Product = $signed(a) * $signed({1'b0,b}), truncated to P_W LSBs (wraps, no saturation).
//   - The multiplier is external; this block only pins the width contract.
//  FSM: RUN / DRAIN / HALT
//   - RUN   -> DRAIN : flush=1. No new grant in the cycle flush is seen.
//   - DRAIN -> HALT  : inflight==0.
//   - DRAIN -> RUN   : flush deasserts before the pipeline is empty (the drain still completes).
//   - HALT  -> RUN   : flush=0. Granting resumes the next cycle; the pointer is preserved.
//   - DRAIN/HALT: req_ready=0. In-flight results still return normally.
//  inflight: +1 on accept, -1 on result; both in the same cycle leaves it unchanged.
// TESTING
//  1 Single op: req0 a=-3, b=1023 -> ready0 same cycle; 2 cycles later res_valid=0001, res_data=-3069.
//  2 All 4 valid every cycle for 8 cycles -> grants 0,1,2,3,0,1,2,3; res tags in the same order,
//    one per cycle; inflight steady at 2.
//  3 Wrap: a=-32768, b=1023 -> res_data=25'd32768 (full product -33521664 truncated).
//  4 Pointer: grant to 2, then only req1 and req3 valid -> req3 granted first, then req1.
//  5 Flush mid-stream with all valid -> ready drops the same cycle, the 2 in-flight results return,
//    idle=1 in HALT; release flush -> grants resume at the saved pointer.
//  6 ap_rst pulsed with 2 ops in flight -> no res_valid afterwards; pointer 0, inflight 0, idle 1.

Source files
------------

// File: rtl/topo2a_mul_arbiter.sv
// rtl/topo2a_mul_arbiter.sv - round-robin arbiter sharing one 16s x 10u multiplier among NREQ lanes
// Registers the winner's operands, pipelines the product and returns it with a one-hot tag.
module topo2a_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int A_W     = 16,
    parameter int B_W     = 10,
    parameter int P_W     = 25,
    parameter int MUL_LAT = 1
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic [NREQ-1:0]                  req_valid,
    output logic [NREQ-1:0]                  req_ready,
    input  logic [NREQ*A_W-1:0]              req_a,
    input  logic [NREQ*B_W-1:0]              req_b,
    output logic [A_W-1:0]                   mul_din0,
    output logic [B_W-1:0]                   mul_din1,
    input  logic [P_W-1:0]                   mul_dout,
    output logic [NREQ-1:0]                  res_valid,
    output logic [P_W-1:0]                   res_data,
    input  logic                             flush,
    output logic                             idle,
    output logic [$clog2(MUL_LAT+2)-1:0]     inflight
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(MUL_LAT+2);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

    state_t            state, state_nx;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     gnt_idx;
    logic [NREQ-1:0]   gnt;
    logic              gnt_any;
    logic              can_grant;
    int                idx;

    logic              v0;
    logic [NREQ-1:0]   tag0;
    logic [MUL_LAT-1:0] s_v;
    logic [NREQ-1:0]   s_tag  [MUL_LAT];
    logic [P_W-1:0]    s_data [MUL_LAT];
    logic              ret;

    // Grants are suppressed in the very cycle flush is first seen, and while reset is asserted.
    assign can_grant = (state == ST_RUN) && !flush && !ap_rst;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        if (can_grant) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NREQ) begin
                    idx = idx - NREQ;
                end
                if (!gnt_any && req_valid[idx]) begin
                    gnt_any  = 1'b1;
                    gnt_idx  = PW'(idx);
                    gnt[idx] = 1'b1;
                end
            end
        end
    end

    assign req_ready = gnt;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Operand register: holds its last value when nothing is granted.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            mul_din0 <= '0;
            mul_din1 <= '0;
            tag0     <= '0;
            v0       <= 1'b0;
        end else begin
            v0   <= gnt_any;
            tag0 <= gnt;
            if (gnt_any) begin
                mul_din0 <= req_a[gnt_idx*A_W +: A_W];
                mul_din1 <= req_b[gnt_idx*B_W +: B_W];
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s_v <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                s_tag[i]  <= '0;
                s_data[i] <= '0;
            end
        end else begin
            s_v[0]    <= v0;
            s_tag[0]  <= tag0;
            s_data[0] <= mul_dout;
            for (int i = 1; i < MUL_LAT; i++) begin
                s_v[i]    <= s_v[i-1];
                s_tag[i]  <= s_tag[i-1];
                s_data[i] <= s_data[i-1];
            end
        end
    end

    assign ret       = s_v[MUL_LAT-1];
    assign res_valid = ret ? s_tag[MUL_LAT-1] : '0;
    assign res_data  = ret ? s_data[MUL_LAT-1] : '0;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            inflight <= '0;
        end else begin
            case ({gnt_any, ret})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN: begin
                if (flush) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (inflight == '0) begin
                    state_nx = ST_HALT;
                end else if (!flush) begin
                    state_nx = ST_RUN;
                end
            end
            ST_HALT: begin
                if (!flush) begin
                    state_nx = ST_RUN;
                end
            end
            default: state_nx = ST_RUN;
        endcase
    end

    assign idle = (state == ST_HALT) || ((state == ST_RUN) && (inflight == '0) && !gnt_any);

endmodule

// File: tb/tb_topo2a_mul_arbiter.sv
// tb/tb_topo2a_mul_arbiter.sv - randomized self-checking bench for topo2a_mul_arbiter
// A queue of expected results with due cycles stands in for the pipeline.
module tb_topo2a_mul_arbiter;

    localparam int NREQ    = 4;
    localparam int A_W     = 16;
    localparam int B_W     = 10;
    localparam int P_W     = 25;
    localparam int MUL_LAT = 1;
    localparam int CW      = $clog2(MUL_LAT+2);

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_HALT  = 2;

    typedef struct {
        logic [NREQ-1:0] tag;
        logic [P_W-1:0]  data;
        int              due;
    } exp_t;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*A_W-1:0]  req_a = '0;
    logic [NREQ*B_W-1:0]  req_b = '0;
    logic [A_W-1:0]       mul_din0;
    logic [B_W-1:0]       mul_din1;
    logic [P_W-1:0]       mul_dout;
    logic [NREQ-1:0]      res_valid;
    logic [P_W-1:0]       res_data;
    logic                 flush = 1'b0;
    logic                 idle;
    logic [CW-1:0]        inflight;

    longint               mul_full;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   m_ptr = 0;
    int   m_mode = M_RUN;
    bit   chk_en = 1'b0;
    exp_t q[$];

    logic [NREQ-1:0] s_ready, s_rv;
    logic [P_W-1:0]  s_rd;
    logic            s_idle;
    logic [CW-1:0]   s_infl;

    always #5 ap_clk = ~ap_clk;

    // External multiplier model: signed A times zero-extended B, low P_W bits.
    always_comb begin
        mul_full = longint'($signed(mul_din0)) * longint'({1'b0, mul_din1});
        mul_dout = mul_full[P_W-1:0];
    end

    topo2a_mul_arbiter #(
        .NREQ(NREQ), .A_W(A_W), .B_W(B_W), .P_W(P_W), .MUL_LAT(MUL_LAT)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .res_valid(res_valid), .res_data(res_data),
        .flush(flush), .idle(idle), .inflight(inflight)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called just after a falling edge with inputs already driven; returns after the next falling edge.
    task automatic step();
        logic [NREQ-1:0] e_ready, e_rv;
        logic [P_W-1:0]  e_rd;
        bit              e_idle;
        int              gi, idx, n_before;
        longint          pa;
        exp_t            e;
        #1;
        gi = -1;
        e_ready = '0;
        if (!ap_rst && m_mode == M_RUN && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (gi < 0 && req_valid[idx]) gi = idx;
            end
        end
        if (gi >= 0) e_ready[gi] = 1'b1;
        e_rv = '0;
        e_rd = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e_rv = q[0].tag;
            e_rd = q[0].data;
        end
        e_idle = (m_mode == M_HALT) || (m_mode == M_RUN && q.size() == 0 && gi < 0);
        s_ready = req_ready;
        s_rv    = res_valid;
        s_rd    = res_data;
        s_idle  = idle;
        s_infl  = inflight;
        if (chk_en) begin
            check("req_ready", 32'(req_ready), 32'(e_ready));
            check("res_valid", 32'(res_valid), 32'(e_rv));
            check("res_data",  32'(res_data),  32'(e_rd));
            check("idle",      32'(idle),      32'(e_idle));
            check("inflight",  32'(inflight),  32'(q.size()));
        end
        if (ap_rst) begin
            q.delete();
            m_ptr  = 0;
            m_mode = M_RUN;
        end else begin
            n_before = q.size();
            if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
            if (gi >= 0) begin
                pa = longint'($signed(req_a[gi*A_W +: A_W])) * longint'(req_b[gi*B_W +: B_W]);
                e.tag  = e_ready;
                e.data = pa[P_W-1:0];
                e.due  = cyc + 1 + MUL_LAT;
                q.push_back(e);
                m_ptr = (gi + 1) % NREQ;
            end
            case (m_mode)
                M_RUN:   if (flush) m_mode = M_DRAIN;
                M_DRAIN: if (n_before == 0) m_mode = M_HALT; else if (!flush) m_mode = M_RUN;
                default: if (!flush) m_mode = M_RUN;
            endcase
        end
        cyc++;
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*A_W +: A_W] = A_W'($urandom);
            req_b[i*B_W +: B_W] = B_W'($urandom);
        end
    endtask

    initial begin
        int last_g, n_res;
        @(negedge ap_clk);
        step();
        ap_rst = 1'b0;
        chk_en = 1'b1;

        #1;
        check("rst_ready",    32'(req_ready), 32'h0);
        check("rst_res",      32'(res_valid), 32'h0);
        check("rst_data",     32'(res_data),  32'h0);
        check("rst_din0",     32'(mul_din0),  32'h0);
        check("rst_din1",     32'(mul_din1),  32'h0);
        check("rst_inflight", 32'(inflight),  32'h0);
        check("rst_idle",     32'(idle),      32'h1);
        step();

        // Single op: -3 * 1023
        req_valid = 4'b0001;
        req_a[0 +: A_W] = -16'sd3;
        req_b[0 +: B_W] = 10'd1023;
        step();
        check("t1_ready", 32'(s_ready), 32'h1);
        req_valid = '0;
        step();
        step();
        check("t1_tag",  32'(s_rv), 32'h1);
        check("t1_data", 32'(s_rd), 32'h1FFF403);

        // Move pointer to 0, then all requesters valid for 8 cycles
        req_valid = 4'b1000;
        step();
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            step();
            check("t2_grant", 32'(s_ready), 32'(1 << (k % NREQ)));
            if (k >= 2) begin
                check("t2_tag",      32'(s_rv),   32'(1 << ((k - 2) % NREQ)));
                check("t2_inflight", 32'(s_infl), 32'h2);
            end
        end
        req_valid = '0;
        step();
        step();
        step();

        // Wrapping product
        req_valid = 4'b0001;
        req_a[0 +: A_W] = 16'h8000;
        req_b[0 +: B_W] = 10'd1023;
        step();
        req_valid = '0;
        step();
        step();
        check("t3_data", 32'(s_rd), 32'h8000);

        // Pointer: grant 2, then only 1 and 3 valid
        req_valid = 4'b0100;
        step();
        check("t4_g2", 32'(s_ready), 32'h4);
        req_valid = 4'b1010;
        step();
        check("t4_first", 32'(s_ready), 32'h8);
        step();
        check("t4_second", 32'(s_ready), 32'h2);
        req_valid = '0;
        step();
        step();
        step();

        // Flush mid-stream
        req_valid = 4'b1111;
        last_g = 0;
        for (int k = 0; k < 5; k++) begin
            rand_ops();
            step();
            for (int i = 0; i < NREQ; i++) if (s_ready[i]) last_g = i;
        end
        flush = 1'b1;
        n_res = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t5_ready", 32'(s_ready), 32'h0);
            if (s_rv != '0) n_res++;
        end
        check("t5_results", 32'(n_res), 32'h2);
        check("t5_idle",    32'(s_idle), 32'h1);
        flush = 1'b0;
        step();
        check("t5_halt_ready", 32'(s_ready), 32'h0);
        step();
        check("t5_resume", 32'(s_ready), 32'(1 << ((last_g + 1) % NREQ)));
        req_valid = '0;
        step();
        step();
        step();

        // Reset with ops in flight
        req_valid = 4'b1111;
        rand_ops();
        step();
        step();
        ap_rst = 1'b1;
        req_valid = '0;
        step();
        ap_rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t6_no_res", 32'(s_rv), 32'h0);
        end
        check("t6_inflight", 32'(s_infl), 32'h0);
        check("t6_idle",     32'(s_idle), 32'h1);
        req_valid = 4'b1111;
        step();
        check("t6_ptr0", 32'(s_ready), 32'h1);

        // Randomized traffic with occasional flush and reset
        for (int n = 0; n < 3000; n++) begin
            req_valid = NREQ'($urandom);
            rand_ops();
            if (flush) begin
                if ($urandom_range(0, 3) == 0) flush = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                flush = 1'b1;
            end
            ap_rst = ($urandom_range(0, 299) == 0);
            step();
        end
        ap_rst = 1'b0;
        flush = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 4; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
